// File: rtl/tmo_timer_if.sv
// Handshake/tick bundle for tmo_timer.
// TMO_RELOAD exists only when the TMO_RELOAD_EN macro is defined.
interface tmo_timer_if #(
  parameter int TMO_WIDTH = 16
);
  logic                 TIM_1MS;
  logic                 TIM_1S;
  logic                 TMO_START;
  logic                 TMO_STOP;
  logic                 TMO_UNIT;
  logic [TMO_WIDTH-1:0] TMO_VALUE;
`ifdef TMO_RELOAD_EN
  logic                 TMO_RELOAD;
`endif
  logic                 TMO_BUSY;
  logic                 TMO_EXPIRE;
  logic [TMO_WIDTH-1:0] TMO_REMAIN;

`ifdef TMO_RELOAD_EN
  modport master (
    output TIM_1MS, TIM_1S, TMO_START, TMO_STOP, TMO_UNIT, TMO_VALUE, TMO_RELOAD,
    input  TMO_BUSY, TMO_EXPIRE, TMO_REMAIN
  );
  modport slave (
    input  TIM_1MS, TIM_1S, TMO_START, TMO_STOP, TMO_UNIT, TMO_VALUE, TMO_RELOAD,
    output TMO_BUSY, TMO_EXPIRE, TMO_REMAIN
  );
`else
  modport master (
    output TIM_1MS, TIM_1S, TMO_START, TMO_STOP, TMO_UNIT, TMO_VALUE,
    input  TMO_BUSY, TMO_EXPIRE, TMO_REMAIN
  );
  modport slave (
    input  TIM_1MS, TIM_1S, TMO_START, TMO_STOP, TMO_UNIT, TMO_VALUE,
    output TMO_BUSY, TMO_EXPIRE, TMO_REMAIN
  );
`endif
endinterface

// File: rtl/tmo_timer.sv
// Tick-driven countdown timeout timer (1 ms / 1 s ticks), registered outputs.
// Optional periodic mode enabled by defining TMO_RELOAD_EN.
module tmo_timer #(
  parameter int TMO_WIDTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  tmo_timer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [TMO_WIDTH-1:0] r_cnt;
  logic                 r_unit;
  logic                 r_busy;
  logic                 r_expire;
`ifdef TMO_RELOAD_EN
  logic [TMO_WIDTH-1:0] r_value;
  logic                 r_reload;
`endif

  logic w_tick;
  logic w_last;
  logic w_zero_val;

  assign w_tick     = r_unit ? bus.TIM_1S : bus.TIM_1MS;
  assign w_last     = (r_cnt == {{(TMO_WIDTH-1){1'b0}}, 1'b1});
  assign w_zero_val = (bus.TMO_VALUE == {TMO_WIDTH{1'b0}});

  // START has priority over STOP and over any tick/expiry in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= {TMO_WIDTH{1'b0}};
      r_unit   <= 1'b0;
      r_busy   <= 1'b0;
      r_expire <= 1'b0;
`ifdef TMO_RELOAD_EN
      r_value  <= {TMO_WIDTH{1'b0}};
      r_reload <= 1'b0;
`endif
    end else begin
      r_expire <= 1'b0;
      if (bus.TMO_START) begin
        r_unit   <= bus.TMO_UNIT;
`ifdef TMO_RELOAD_EN
        r_value  <= bus.TMO_VALUE;
        r_reload <= bus.TMO_RELOAD;
`endif
        if (w_zero_val) begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_cnt    <= {TMO_WIDTH{1'b0}};
          r_expire <= 1'b1;
        end else begin
          r_state  <= RUN;
          r_busy   <= 1'b1;
          r_cnt    <= bus.TMO_VALUE;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
            r_cnt  <= {TMO_WIDTH{1'b0}};
          end
          RUN: begin
            if (bus.TMO_STOP) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= {TMO_WIDTH{1'b0}};
            end else if (w_tick) begin
              if (w_last) begin
                r_expire <= 1'b1;
`ifdef TMO_RELOAD_EN
                if (r_reload) begin
                  r_cnt <= r_value;
                end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= {TMO_WIDTH{1'b0}};
                end
`else
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= {TMO_WIDTH{1'b0}};
`endif
              end else begin
                r_cnt <= r_cnt - {{(TMO_WIDTH-1){1'b0}}, 1'b1};
              end
            end else begin
              r_cnt <= r_cnt;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= {TMO_WIDTH{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.TMO_BUSY   = r_busy;
  assign bus.TMO_EXPIRE = r_expire;
  assign bus.TMO_REMAIN = r_cnt;

endmodule

// File: tb/tb_tmo_timer.sv
// Directed + randomized bench for tmo_timer against a cycle-level reference model.
module tb_tmo_timer;
  localparam int W = 16;
`ifdef TMO_RELOAD_EN
  localparam bit REL_OK = 1'b1;
`else
  localparam bit REL_OK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  tmo_timer_if #(.TMO_WIDTH(W)) bus ();
  tmo_timer #(.TMO_WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: what the outputs must read after the current edge.
  bit m_busy, m_exp, m_unit, m_rel;
  int m_rem, m_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".busy"},   {31'd0, bus.TMO_BUSY},   {31'd0, m_busy});
    chk({tag, ".expire"}, {31'd0, bus.TMO_EXPIRE}, {31'd0, m_exp});
    chk({tag, ".remain"}, {16'd0, bus.TMO_REMAIN}, m_rem);
  endtask

  task automatic step(input string tag, input bit start, input bit stop, input bit unit,
                      input bit reload, input bit t1ms, input bit t1s, input int value);
    bus.TMO_START = start;
    bus.TMO_STOP  = stop;
    bus.TMO_UNIT  = unit;
    bus.TIM_1MS   = t1ms;
    bus.TIM_1S    = t1s;
    bus.TMO_VALUE = W'(value);
`ifdef TMO_RELOAD_EN
    bus.TMO_RELOAD = reload;
`endif
    @(posedge clk);
    #1;
    m_exp = 1'b0;
    if (start) begin
      m_unit = unit;
      m_rel  = reload;
      m_val  = value;
      if (m_val == 0) begin
        m_busy = 1'b0; m_rem = 0; m_exp = 1'b1;
      end else begin
        m_busy = 1'b1; m_rem = m_val;
      end
    end else if (m_busy && stop) begin
      m_busy = 1'b0; m_rem = 0;
    end else if (m_busy && (m_unit ? t1s : t1ms)) begin
      if (m_rem > 1) m_rem = m_rem - 1;
      else begin
        m_exp = 1'b1;
        if (m_rel) m_rem = m_val;
        else begin m_busy = 1'b0; m_rem = 0; end
      end
    end
    bus.TMO_START = 1'b0;
    bus.TMO_STOP  = 1'b0;
    bus.TIM_1MS   = 1'b0;
    bus.TIM_1S    = 1'b0;
    chk_outs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    m_busy = 1'b0; m_exp = 1'b0; m_rem = 0; m_rel = 1'b0; m_unit = 1'b0; m_val = 0;
    chk_outs({tag, ".async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_outs({tag, ".rel"});
  endtask

  initial begin
    bus.TMO_START = 1'b0; bus.TMO_STOP = 1'b0; bus.TMO_UNIT = 1'b0;
    bus.TIM_1MS = 1'b0; bus.TIM_1S = 1'b0; bus.TMO_VALUE = '0;
`ifdef TMO_RELOAD_EN
    bus.TMO_RELOAD = 1'b0;
`endif
    rst = 1'b1;
    #3;
    do_reset("reset");
    idle(2);

    // Basic countdown on 1 ms ticks, value 3.
    step("arm3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("arm3.rem_const", {16'd0, bus.TMO_REMAIN}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      idle(9);
      step("tick_ms", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("cnt3.rem_const", {16'd0, bus.TMO_REMAIN}, (k == 2) ? 32'd0 : 32'(2 - k));
    end
    chk("cnt3.expire_const", {31'd0, bus.TMO_EXPIRE}, 32'd1);
    idle(1);
    chk("cnt3.expire_once", {31'd0, bus.TMO_EXPIRE}, 32'd0);

    // Unit select: only 1 s ticks count.
    step("arm_s2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    for (int k = 0; k < 5; k++) step("ms_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step("s_tick1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step("s_tick2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("unit.expire_const", {31'd0, bus.TMO_EXPIRE}, 32'd1);
    idle(1);

    // Stop coincident with the final tick, then zero-value start.
    step("arm2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    step("tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step("stop_last", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(2);
    step("arm0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("arm0.expire_const", {31'd0, bus.TMO_EXPIRE}, 32'd1);
    idle(2);
    step("stop_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Restart coincident with a tick; then held tick counts per cycle.
    step("arm5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    step("tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step("tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step("rearm4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    chk("rearm4.rem_const", {16'd0, bus.TMO_REMAIN}, 32'd4);
    for (int k = 0; k < 4; k++) step("held_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9);
    chk("rearm4.expire_const", {31'd0, bus.TMO_EXPIRE}, 32'd1);
    idle(1);

    // Start and stop together: start wins; last-tick restart suppresses expiry.
    step("start_stop", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    step("restart_last", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    step("stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Reset mid-count discards everything.
    step("arm5r", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    step("tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step("tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_reset("midreset");
    for (int k = 0; k < 10; k++) begin
      step("post_rst_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idle(1);
    end

`ifdef TMO_RELOAD_EN
    // Periodic mode: expiry every second tick, busy stays high.
    step("arm_rel2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    for (int k = 1; k <= 8; k++) begin
      step("rel_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("rel.expire_const", {31'd0, bus.TMO_EXPIRE}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rel.busy_const", {31'd0, bus.TMO_BUSY}, 32'd1);
    end
    step("rel_stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step("rand",
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 23) == 0),
           1'($urandom_range(0, 1)),
           REL_OK & 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
